stream_mux_rr: RTL

- Parametrised N-to-1 registered stream multiplexer; successor to the combinational 2-to-1 mux.
- Selects one of NChannels valid/ready input channels and forwards its word through one output register stage.
- Selection is either explicit (Selector input) or round-robin arbitration.
- Sits between producers (e.g. register-file/ALU/memory result sources) and a single consumer that applies backpressure.

---
 rtl/stream_mux_rr.sv | 96 +++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-to-1 registered valid/ready stream mux, fixed-select or round-robin.
// Define STREAM_MUX_XFER_COUNT_EN to add the Xfer_Count output-transfer counter.
module stream_mux_rr #(
  parameter  int NBits     = 32,
  parameter  int NChannels = 4,
  localparam int SelBits   = $clog2(NChannels)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Mode,
  input  logic [SelBits-1:0]       Selector,
  input  logic [NChannels-1:0]     In_Valid,
  input  logic [NChannels*NBits-1:0] In_Data,
  output logic [NChannels-1:0]     In_Ready,
  output logic                     Out_Valid,
  output logic [NBits-1:0]         Out_Data,
  output logic [SelBits-1:0]       Out_Channel,
  input  logic                     Out_Ready
`ifdef STREAM_MUX_XFER_COUNT_EN
  ,
  output logic [31:0]              Xfer_Count
`endif
);

  logic [SelBits-1:0] last;
  logic [SelBits-1:0] gnt;
  logic               gnt_vld;
  logic               can_load;
  logic               xfer_in;
  logic               xfer_out;
  logic [NBits-1:0]   sel_data;
  int                 idx;

  assign can_load = !Out_Valid || Out_Ready;
  assign xfer_in  = gnt_vld && can_load;
  assign xfer_out = Out_Valid && Out_Ready;

  // Round-robin search starts one past the last granted channel
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (!Mode) begin
      for (int i = 0; i < NChannels; i++) begin
        if (Selector == SelBits'(i) && In_Valid[i]) begin
          gnt     = SelBits'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NChannels; k++) begin
        idx = int'(last) + k;
        if (idx >= NChannels) idx = idx - NChannels;
        if (!gnt_vld && In_Valid[idx]) begin
          gnt     = SelBits'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    In_Ready = '0;
    sel_data = '0;
    for (int i = 0; i < NChannels; i++) begin
      if (gnt == SelBits'(i)) begin
        sel_data    = In_Data[i*NBits +: NBits];
        In_Ready[i] = xfer_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Out_Valid   <= 1'b0;
      Out_Data    <= '0;
      Out_Channel <= '0;
      last        <= SelBits'(NChannels - 1);
    end else if (xfer_in) begin
      Out_Valid   <= 1'b1;
      Out_Data    <= sel_data;
      Out_Channel <= gnt;
      if (Mode) last <= gnt;
    end else if (xfer_out) begin
      Out_Valid   <= 1'b0;
    end
  end

`ifdef STREAM_MUX_XFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)         Xfer_Count <= '0;
    else if (xfer_out) Xfer_Count <= Xfer_Count + 32'd1;
  end
`endif

endmodule
